// File: rtl/step_chart_reader.sv
// Step-chart reader: walks a chart ROM one row per FRAMES_PER_ROW frame
// ticks and presents each row's arrow pattern to the sprite manager
// together with a one-cycle shiftUp strobe. A one-entry prefetch register
// hides the synchronous ROM latency. Rest rows and a trailing run of blank
// drain rows are generated locally.
module step_chart_reader #(
    parameter int ADDR_W         = 8,
    parameter int FRAMES_PER_ROW = 8,
    parameter int DRAIN_ROWS     = 6
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic              pause,
    input  logic              frame_tick,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [3:0]        stripArrows,
    output logic              shiftUp,
    output logic [ADDR_W-1:0] row_index,
    output logic              busy,
    output logic              done,
    output logic              chart_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX   = {ADDR_W{1'b1}};
    localparam logic [7:0]        FRAME_LAST = 8'(FRAMES_PER_ROW - 1);
    localparam logic [8:0]        DRAIN_LEN  = 9'(DRAIN_ROWS);
    localparam logic [7:0]        END_MARK   = 8'hFF;

    // Three or more simultaneous arrows cannot be stepped on; flag them.
    function automatic logic pattern_illegal(input logic [3:0] pat);
        logic [2:0] ones;
        ones = 3'(pat[0]) + 3'(pat[1]) + 3'(pat[2]) + 3'(pat[3]);
        return (ones >= 3'd3);
    endfunction

    state_t            state_q, state_d;
    logic              prime_ph_q, prime_ph_d;   // second PRIME cycle
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [3:0]        strip_q, strip_d;
    logic              shift_q, shift_d;
    logic [ADDR_W-1:0] row_index_q, row_index_d;
    logic              err_q, err_d;
    logic [7:0]        frame_q, frame_d;
    logic [3:0]        rest_q, rest_d;
    logic [7:0]        drain_q, drain_d;
    logic [7:0]        pf_q, pf_d;               // prefetched chart entry
    logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;     // address of pf_q
    logic              fill_q, fill_d;           // refill pf_q this cycle
    logic              exhausted_q, exhausted_d; // last ROM entry consumed
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic tick_s;
    logic boundary_s;
    logic pf_end_s;
    logic drain_last_s;

    assign tick_s       = frame_tick && !pause && ((state_q == S_RUN) || (state_q == S_DRAIN));
    assign boundary_s   = tick_s && (frame_q == FRAME_LAST);
    assign pf_end_s     = (pf_q == END_MARK) || exhausted_q;
    assign drain_last_s = (({1'b0, drain_q} + 9'd1) >= DRAIN_LEN);

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_PRIME;
                else       state_d = state_q;
            end
            S_PRIME: begin
                if (prime_ph_q) state_d = S_RUN;
                else            state_d = S_PRIME;
            end
            S_RUN: begin
                if (boundary_s && (rest_q == 4'd0) && pf_end_s) begin
                    // The row emitted here is already the first drain row.
                    if (DRAIN_LEN <= 9'd1) state_d = S_DONE;
                    else                   state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (boundary_s && drain_last_s) state_d = S_DONE;
                else                            state_d = S_DRAIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values, driven by the current state.
    always_comb begin
        prime_ph_d  = prime_ph_q;
        rom_addr_d  = rom_addr_q;
        strip_d     = strip_q;
        shift_d     = 1'b0;
        row_index_d = row_index_q;
        err_d       = err_q;
        frame_d     = frame_q;
        rest_d      = rest_q;
        drain_d     = drain_q;
        pf_d        = pf_q;
        pf_addr_d   = pf_addr_q;
        fill_d      = fill_q;
        exhausted_d = exhausted_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    rom_addr_d  = '0;
                    frame_d     = 8'd0;
                    rest_d      = 4'd0;
                    drain_d     = 8'd0;
                    err_d       = 1'b0;
                    prime_ph_d  = 1'b0;
                    fill_d      = 1'b0;
                    exhausted_d = 1'b0;
                end else begin
                    rom_addr_d = rom_addr_q;
                end
            end
            S_PRIME: begin
                if (prime_ph_q) begin
                    // ROM word for address 0 is valid now.
                    pf_d       = rom_data;
                    pf_addr_d  = '0;
                    rom_addr_d = ADDR_W'(1);
                    prime_ph_d = 1'b0;
                end else begin
                    prime_ph_d = 1'b1;
                end
            end
            S_RUN: begin
                if (fill_q) begin
                    pf_d      = rom_data;
                    pf_addr_d = rom_addr_q;
                    fill_d    = 1'b0;
                    // Stop at the top of the ROM rather than wrapping to 0.
                    if (rom_addr_q != ADDR_MAX) rom_addr_d = rom_addr_q + ADDR_W'(1);
                    else                        rom_addr_d = rom_addr_q;
                end else begin
                    fill_d = fill_q;
                end
                if (tick_s) begin
                    if (frame_q == FRAME_LAST) frame_d = 8'd0;
                    else                       frame_d = frame_q + 8'd1;
                end else begin
                    frame_d = frame_q;
                end
                if (boundary_s) begin
                    shift_d = 1'b1;
                    if (rest_q != 4'd0) begin
                        strip_d = 4'b0000;
                        rest_d  = rest_q - 4'd1;
                    end else if (pf_end_s) begin
                        strip_d = 4'b0000;
                        drain_d = 8'd1;
                    end else begin
                        if (pattern_illegal(pf_q[7:4])) begin
                            strip_d = 4'b0000;
                            err_d   = 1'b1;
                        end else begin
                            strip_d = pf_q[7:4];
                        end
                        rest_d      = pf_q[3:0];
                        row_index_d = pf_addr_q;
                        if (pf_addr_q == ADDR_MAX) exhausted_d = 1'b1;
                        else                       fill_d      = 1'b1;
                    end
                end else begin
                    shift_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (tick_s) begin
                    if (frame_q == FRAME_LAST) frame_d = 8'd0;
                    else                       frame_d = frame_q + 8'd1;
                end else begin
                    frame_d = frame_q;
                end
                if (boundary_s) begin
                    shift_d = 1'b1;
                    strip_d = 4'b0000;
                    drain_d = drain_q + 8'd1;
                end else begin
                    shift_d = 1'b0;
                end
            end
            default: begin
                shift_d = 1'b0;
            end
        endcase

        busy_d = (state_d == S_PRIME) || (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // Datapath and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            prime_ph_q  <= 1'b0;
            rom_addr_q  <= '0;
            strip_q     <= 4'b0000;
            shift_q     <= 1'b0;
            row_index_q <= '0;
            err_q       <= 1'b0;
            frame_q     <= 8'd0;
            rest_q      <= 4'd0;
            drain_q     <= 8'd0;
            pf_q        <= 8'd0;
            pf_addr_q   <= '0;
            fill_q      <= 1'b0;
            exhausted_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            prime_ph_q  <= prime_ph_d;
            rom_addr_q  <= rom_addr_d;
            strip_q     <= strip_d;
            shift_q     <= shift_d;
            row_index_q <= row_index_d;
            err_q       <= err_d;
            frame_q     <= frame_d;
            rest_q      <= rest_d;
            drain_q     <= drain_d;
            pf_q        <= pf_d;
            pf_addr_q   <= pf_addr_d;
            fill_q      <= fill_d;
            exhausted_q <= exhausted_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign stripArrows = strip_q;
    assign shiftUp     = shift_q;
    assign row_index   = row_index_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign chart_err   = err_q;

endmodule

// File: tb/tb_step_chart_reader.sv
// Directed bench for step_chart_reader. dut1: ADDR_W=8, FRAMES_PER_ROW=2.
// dut2: ADDR_W=2, FRAMES_PER_ROW=1, for end-of-ROM behaviour.
module tb_step_chart_reader;

    logic       Clk;
    logic       Reset_n;
    logic       start1, start2;
    logic       pause;
    logic       frame_tick;

    logic [7:0] rom_addr1, rom_data1, row_index1;
    logic [3:0] strip1;
    logic       shift1, busy1, done1, err1;

    logic [1:0] rom_addr2, row_index2;
    logic [7:0] rom_data2;
    logic [3:0] strip2;
    logic       shift2, busy2, done2, err2;

    logic [7:0] rom1 [0:255];
    logic [7:0] rom2 [0:3];

    int         checks;
    int         failures;
    int         pc1, pc2;
    logic [3:0] log1 [0:63];
    logic [3:0] log2 [0:63];
    logic [1:0] prev2;
    logic       wrap2;

    step_chart_reader #(.ADDR_W(8), .FRAMES_PER_ROW(2), .DRAIN_ROWS(6)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .start(start1), .pause(pause),
        .frame_tick(frame_tick), .rom_addr(rom_addr1), .rom_data(rom_data1),
        .stripArrows(strip1), .shiftUp(shift1), .row_index(row_index1),
        .busy(busy1), .done(done1), .chart_err(err1)
    );

    step_chart_reader #(.ADDR_W(2), .FRAMES_PER_ROW(1), .DRAIN_ROWS(6)) dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .start(start2), .pause(pause),
        .frame_tick(frame_tick), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .stripArrows(strip2), .shiftUp(shift2), .row_index(row_index2),
        .busy(busy2), .done(done2), .chart_err(err2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous chart ROMs.
    always @(posedge Clk) begin
        rom_data1 <= rom1[rom_addr1];
        rom_data2 <= rom2[rom_addr2];
    end

    // Row loggers, sampled on the falling edge.
    always @(negedge Clk) begin
        if (shift1) begin
            log1[pc1[5:0]] <= strip1;
            pc1 <= pc1 + 1;
        end
        if (shift2) begin
            log2[pc2[5:0]] <= strip2;
            pc2 <= pc2 + 1;
        end
        if ((busy2 || done2) && (prev2 != 2'd0) && (rom_addr2 == 2'd0)) wrap2 <= 1'b1;
        prev2 <= rom_addr2;
    end

    task automatic do_tick();
        @(negedge Clk) frame_tick = 1'b1;
        @(negedge Clk) frame_tick = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        Reset_n = 1'b0; start1 = 1'b0; start2 = 1'b0; pause = 1'b0; frame_tick = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic load_rom1(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        for (int i = 0; i < 256; i++) rom1[i] = 8'hFF;
        rom1[0] = a; rom1[1] = b; rom1[2] = c;
    endtask

    // Start with a tick coincident with start and another during PRIME.
    task automatic start_run(input int which, output logic [7:0] a_n2,
                             output logic [7:0] a_n3, output int base);
        @(negedge Clk);
        if (which == 1) start1 = 1'b1; else start2 = 1'b1;
        frame_tick = 1'b1;
        @(negedge Clk);
        start1 = 1'b0; start2 = 1'b0;
        @(negedge Clk);
        frame_tick = 1'b0;
        a_n2 = (which == 1) ? rom_addr1 : {6'b0, rom_addr2};
        @(negedge Clk);
        a_n3 = (which == 1) ? rom_addr1 : {6'b0, rom_addr2};
        base = (which == 1) ? pc1 : pc2;
    endtask

    task automatic test_reset();
        Reset_n = 1'b1;
        #2 Reset_n = 1'b0;
        #1;
        checks++; if (rom_addr1 !== 8'd0) begin failures++; $display("FAIL reset_rom_addr got=%h want=00", rom_addr1); end
        checks++; if (strip1 !== 4'd0) begin failures++; $display("FAIL reset_strip got=%b want=0000", strip1); end
        checks++; if ({shift1, busy1, done1, err1} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b want=0000", {shift1, busy1, done1, err1}); end
        checks++; if (row_index1 !== 8'd0) begin failures++; $display("FAIL reset_row_index got=%h want=00", row_index1); end
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (4) @(negedge Clk);
        checks++; if ({busy1, done1, busy2, done2} !== 4'b0000) begin failures++; $display("FAIL reset_stays_idle got=%b want=0000", {busy1, done1, busy2, done2}); end
    endtask

    task automatic test_basic();
        logic [7:0] a2, a3;
        int base;
        logic [3:0] e [0:8];
        e = '{4'h4, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        load_rom1(8'h40, 8'h11, 8'hFF);
        start_run(1, a2, a3, base);
        checks++; if (a2 !== 8'd0) begin failures++; $display("FAIL basic_prime_addr0 got=%h want=00", a2); end
        checks++; if (a3 !== 8'd1) begin failures++; $display("FAIL basic_prime_addr1 got=%h want=01", a3); end
        checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b want=1", busy1); end
        do_tick();
        checks++; if (pc1 - base !== 0) begin failures++; $display("FAIL basic_no_early_pulse got=%0d want=0", pc1 - base); end
        do_tick();
        checks++; if (pc1 - base !== 1) begin failures++; $display("FAIL basic_first_pulse got=%0d want=1", pc1 - base); end
        checks++; if (row_index1 !== 8'd0) begin failures++; $display("FAIL basic_row_index0 got=%h want=00", row_index1); end
        ticks(16);
        checks++; if (pc1 - base !== 9) begin failures++; $display("FAIL basic_pulse_count got=%0d want=9", pc1 - base); end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (log1[6'(base + i)] !== e[i]) begin failures++; $display("FAIL basic_row%0d got=%b want=%b", i, log1[6'(base + i)], e[i]); end
        end
        checks++; if ({busy1, done1} !== 2'b01) begin failures++; $display("FAIL basic_done got=%b want=01", {busy1, done1}); end
        checks++; if (row_index1 !== 8'd1) begin failures++; $display("FAIL basic_row_index1 got=%h want=01", row_index1); end
        checks++; if (rom_addr1 !== 8'd3) begin failures++; $display("FAIL basic_rom_addr_end got=%h want=03", rom_addr1); end
        ticks(4);
        checks++; if (pc1 - base !== 9) begin failures++; $display("FAIL basic_no_pulse_in_done got=%0d want=9", pc1 - base); end
    endtask

    task automatic test_rest();
        logic [7:0] a2, a3;
        int base;
        load_rom1(8'h83, 8'hFF, 8'hFF);
        start_run(1, a2, a3, base);
        ticks(2);
        checks++; if (log1[6'(base)] !== 4'b1000) begin failures++; $display("FAIL rest_first_row got=%b want=1000", log1[6'(base)]); end
        checks++; if (row_index1 !== 8'd0) begin failures++; $display("FAIL rest_row_index got=%h want=00", row_index1); end
        ticks(18);
        checks++; if (pc1 - base !== 10) begin failures++; $display("FAIL rest_pulse_count got=%0d want=10", pc1 - base); end
        for (int i = 1; i < 10; i++) begin
            checks++;
            if (log1[6'(base + i)] !== 4'b0000) begin failures++; $display("FAIL rest_row%0d got=%b want=0000", i, log1[6'(base + i)]); end
        end
        checks++; if (done1 !== 1'b1) begin failures++; $display("FAIL rest_done got=%b want=1", done1); end
    endtask

    task automatic test_err();
        logic [7:0] a2, a3;
        int base;
        load_rom1(8'hE0, 8'hFF, 8'hFF);
        start_run(1, a2, a3, base);
        ticks(2);
        checks++; if (pc1 - base !== 1) begin failures++; $display("FAIL err_pulse got=%0d want=1", pc1 - base); end
        checks++; if (strip1 !== 4'b0000) begin failures++; $display("FAIL err_strip got=%b want=0000", strip1); end
        checks++; if (err1 !== 1'b1) begin failures++; $display("FAIL err_flag_set got=%b want=1", err1); end
        ticks(12);
        checks++; if (pc1 - base !== 7) begin failures++; $display("FAIL err_pulse_count got=%0d want=7", pc1 - base); end
        checks++; if ({err1, done1} !== 2'b11) begin failures++; $display("FAIL err_sticky got=%b want=11", {err1, done1}); end
        start_run(1, a2, a3, base);
        checks++; if (err1 !== 1'b0) begin failures++; $display("FAIL err_cleared_by_start got=%b want=0", err1); end
    endtask

    task automatic test_pause();
        logic [7:0] a2, a3;
        int base;
        apply_reset();
        load_rom1(8'h40, 8'hFF, 8'hFF);
        start_run(1, a2, a3, base);
        do_tick();
        pause = 1'b1;
        ticks(5);
        pause = 1'b0;
        checks++; if (pc1 - base !== 0) begin failures++; $display("FAIL pause_held got=%0d want=0", pc1 - base); end
        do_tick();
        checks++; if (pc1 - base !== 1) begin failures++; $display("FAIL pause_resume got=%0d want=1", pc1 - base); end
        checks++; if (log1[6'(base)] !== 4'b0100) begin failures++; $display("FAIL pause_row got=%b want=0100", log1[6'(base)]); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] a2, a3;
        int base, cnt;
        apply_reset();
        load_rom1(8'h60, 8'h90, 8'hFF);
        start_run(1, a2, a3, base);
        do_tick();
        @(negedge Clk) frame_tick = 1'b1;
        @(negedge Clk) frame_tick = 1'b0;
        #1;
        checks++; if ({shift1, strip1, err1} !== 6'b1_0110_0) begin failures++; $display("FAIL mid_pulse got=%b want=101100", {shift1, strip1, err1}); end
        @(negedge Clk) Reset_n = 1'b0;
        #1;
        checks++; if ({rom_addr1, row_index1} !== 16'd0) begin failures++; $display("FAIL mid_reset_addr got=%h want=0000", {rom_addr1, row_index1}); end
        checks++; if ({strip1, shift1, busy1, done1, err1} !== 8'd0) begin failures++; $display("FAIL mid_reset_outputs got=%b want=00000000", {strip1, shift1, busy1, done1, err1}); end
        @(negedge Clk) Reset_n = 1'b1;
        cnt = pc1;
        ticks(4);
        checks++; if (pc1 !== cnt) begin failures++; $display("FAIL mid_no_pulse got=%0d want=%0d", pc1, cnt); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL mid_idle got=%b want=0", busy1); end
        start_run(1, a2, a3, base);
        ticks(2);
        checks++; if (log1[6'(base)] !== 4'b0110) begin failures++; $display("FAIL mid_replay_row0 got=%b want=0110", log1[6'(base)]); end
        checks++; if (row_index1 !== 8'd0) begin failures++; $display("FAIL mid_replay_idx0 got=%h want=00", row_index1); end
        ticks(2);
        checks++; if (log1[6'(base + 1)] !== 4'b1001) begin failures++; $display("FAIL mid_replay_row1 got=%b want=1001", log1[6'(base + 1)]); end
        checks++; if (row_index1 !== 8'd1) begin failures++; $display("FAIL mid_replay_idx1 got=%h want=01", row_index1); end
    endtask

    task automatic test_rom_end();
        logic [7:0] a2, a3;
        int base;
        logic [3:0] e [0:10];
        e = '{4'h1, 4'h2, 4'h4, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        apply_reset();
        rom2[0] = 8'h10; rom2[1] = 8'h20; rom2[2] = 8'h41; rom2[3] = 8'h80;
        wrap2 = 1'b0;
        start_run(2, a2, a3, base);
        checks++; if (a3 !== 8'd1) begin failures++; $display("FAIL end_prime_addr got=%h want=01", a3); end
        ticks(11);
        checks++; if (pc2 - base !== 11) begin failures++; $display("FAIL end_pulse_count got=%0d want=11", pc2 - base); end
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (log2[6'(base + i)] !== e[i]) begin failures++; $display("FAIL end_row%0d got=%b want=%b", i, log2[6'(base + i)], e[i]); end
        end
        checks++; if (done2 !== 1'b1) begin failures++; $display("FAIL end_done got=%b want=1", done2); end
        checks++; if ({row_index2, rom_addr2} !== 4'b1111) begin failures++; $display("FAIL end_addr got=%b want=1111", {row_index2, rom_addr2}); end
        checks++; if (wrap2 !== 1'b0) begin failures++; $display("FAIL end_no_wrap got=%b want=0", wrap2); end
    endtask

    initial begin
        checks = 0; failures = 0; pc1 = 0; pc2 = 0;
        start1 = 1'b0; start2 = 1'b0; pause = 1'b0; frame_tick = 1'b0;
        prev2 = 2'd0; wrap2 = 1'b0;
        for (int i = 0; i < 256; i++) rom1[i] = 8'hFF;
        for (int i = 0; i < 4; i++) rom2[i] = 8'hFF;
        test_reset();
        test_basic();
        test_rest();
        test_err();
        test_pause();
        test_reset_mid();
        test_rom_end();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
